// File: rtl/pipe_front_ctrl_if.sv
// Signal bundle between the hazard unit / fetch side and the front-end pipeline
// register controller. clk and rst are kept outside the bundle.
interface pipe_front_ctrl_if #(
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
);
    // There is no valid/ready pairing on this bundle: every directive is a level
    // sampled at each rising clk edge, and every output is a registered value
    // that is stable for the whole following cycle.
    logic              PcWrite;
    logic              IRWrite;
    logic              zeroCntrl;
    logic              flush;
    logic              PcSrc;
    logic              Jmp;
    logic [31:0]       branchTarget;
    logic [31:0]       jumpTarget;
    logic [31:0]       instrIn;
    logic [CTRL_W-1:0] ctrlIn;

    logic [31:0]       pcOut;
    logic [31:0]       ifidInstr;
    logic [31:0]       ifidPc4;
    logic              ifidValid;
    logic [CTRL_W-1:0] idexCtrl;
    logic              idexValid;
    logic [1:0]        pipeState;
    logic [CNT_W-1:0]  stallCount;
    logic [CNT_W-1:0]  flushCount;
    logic              stallTimeout;

    modport master (
        output PcWrite, IRWrite, zeroCntrl, flush, PcSrc, Jmp,
               branchTarget, jumpTarget, instrIn, ctrlIn,
        input  pcOut, ifidInstr, ifidPc4, ifidValid, idexCtrl, idexValid,
               pipeState, stallCount, flushCount, stallTimeout
    );

    modport slave (
        input  PcWrite, IRWrite, zeroCntrl, flush, PcSrc, Jmp,
               branchTarget, jumpTarget, instrIn, ctrlIn,
        output pcOut, ifidInstr, ifidPc4, ifidValid, idexCtrl, idexValid,
               pipeState, stallCount, flushCount, stallTimeout
    );
endinterface

// File: rtl/pipe_front_ctrl.sv
// Front-end pipeline register controller: owns PC, IF/ID and the ID/EX control
// half, applies holds/flushes/bubbles, and keeps stall/flush statistics.
module pipe_front_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          CTRL_W      = 10,
    parameter int          CNT_W       = 16,
    parameter int          STALL_LIMIT = 8
) (
    input logic               clk,
    input logic               rst,
    pipe_front_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        FLUSH = 2'b11
    } state_t;

    localparam int                RUN_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0]  LIMIT    = RUN_W'(STALL_LIMIT);
    localparam logic [RUN_W-1:0]  LIMIT_M1 = RUN_W'(STALL_LIMIT - 1);

    state_t            state;
    logic [31:0]       pc;
    logic [31:0]       ifid_instr;
    logic [31:0]       ifid_pc4;
    logic              ifid_valid;
    logic [CTRL_W-1:0] idex_ctrl;
    logic              idex_valid;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [RUN_W-1:0]  run_len;
    logic              timeout;

    logic [31:0] pc_plus4;
    logic        accept_flush;

    assign pc_plus4     = pc + 32'd4;
    // A stall outranks a flush presented in the same cycle; the flush is redone later.
    assign accept_flush = bus.IRWrite & bus.flush & ~bus.zeroCntrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ifid_instr <= '0;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
            idex_ctrl  <= '0;
            idex_valid <= 1'b0;
        end else begin
            if (bus.PcWrite) begin
                if (bus.Jmp)        pc <= bus.jumpTarget;
                else if (bus.PcSrc) pc <= bus.branchTarget;
                else                pc <= pc_plus4;
            end
            if (bus.IRWrite) begin
                if (bus.flush) begin
                    ifid_instr <= '0;
                    ifid_pc4   <= '0;
                    ifid_valid <= 1'b0;
                end else begin
                    ifid_instr <= bus.instrIn;
                    ifid_pc4   <= pc_plus4;
                    ifid_valid <= 1'b1;
                end
            end
            if (bus.zeroCntrl) begin
                idex_ctrl  <= '0;
                idex_valid <= 1'b0;
            end else begin
                idex_ctrl  <= bus.ctrlIn;
                idex_valid <= ifid_valid;
            end
        end
    end

    // pipeState records the action taken at the most recent edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else if (bus.zeroCntrl) begin
            state <= STALL;
        end else if (accept_flush) begin
            state <= FLUSH;
        end else begin
            state <= RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            run_len   <= '0;
            timeout   <= 1'b0;
        end else begin
            if (bus.zeroCntrl && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (accept_flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (!bus.zeroCntrl) begin
                run_len <= '0;
            end else if (run_len != LIMIT) begin
                run_len <= run_len + 1'b1;
            end
            // Sticky: set on the edge where the run length reaches the limit.
            if (bus.zeroCntrl && (run_len >= LIMIT_M1)) begin
                timeout <= 1'b1;
            end
        end
    end

    assign bus.pcOut        = pc;
    assign bus.ifidInstr    = ifid_instr;
    assign bus.ifidPc4      = ifid_pc4;
    assign bus.ifidValid    = ifid_valid;
    assign bus.idexCtrl     = idex_ctrl;
    assign bus.idexValid    = idex_valid;
    assign bus.pipeState    = state;
    assign bus.stallCount   = stall_cnt;
    assign bus.flushCount   = flush_cnt;
    assign bus.stallTimeout = timeout;
endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Bench for pipe_front_ctrl: directed vector table, hand-written watchdog and
// reset sequences, then random stimulus against a behavioural model.
module tb_pipe_front_ctrl;
    localparam int CTRL_W = 10;

    logic clk;
    logic rst;

    pipe_front_ctrl_if #(.CTRL_W(CTRL_W), .CNT_W(16)) bus ();
    pipe_front_ctrl_if #(.CTRL_W(CTRL_W), .CNT_W(3))  bus_s ();

    pipe_front_ctrl #(.RESET_PC(32'h0), .CTRL_W(CTRL_W), .CNT_W(16), .STALL_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Small-counter instance exercising saturation and a one-cycle watchdog.
    pipe_front_ctrl #(.RESET_PC(32'h0), .CTRL_W(CTRL_W), .CNT_W(3), .STALL_LIMIT(1)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s)
    );

    assign bus_s.PcWrite      = bus.PcWrite;
    assign bus_s.IRWrite      = bus.IRWrite;
    assign bus_s.zeroCntrl    = bus.zeroCntrl;
    assign bus_s.flush        = bus.flush;
    assign bus_s.PcSrc        = bus.PcSrc;
    assign bus_s.Jmp          = bus.Jmp;
    assign bus_s.branchTarget = bus.branchTarget;
    assign bus_s.jumpTarget   = bus.jumpTarget;
    assign bus_s.instrIn      = bus.instrIn;
    assign bus_s.ctrlIn       = bus.ctrlIn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pcw, input logic irw, input logic zc, input logic fl,
                         input logic src, input logic jmp, input logic [31:0] bt,
                         input logic [31:0] jt, input logic [31:0] instr,
                         input logic [CTRL_W-1:0] ctrl);
        bus.PcWrite = pcw; bus.IRWrite = irw; bus.zeroCntrl = zc; bus.flush = fl;
        bus.PcSrc = src; bus.Jmp = jmp; bus.branchTarget = bt; bus.jumpTarget = jt;
        bus.instrIn = instr; bus.ctrlIn = ctrl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " pcOut"}, bus.pcOut, 32'h0);
        check({tag, " ifidInstr"}, bus.ifidInstr, 32'h0);
        check({tag, " ifidPc4"}, bus.ifidPc4, 32'h0);
        check({tag, " ifidValid"}, {31'b0, bus.ifidValid}, 32'h0);
        check({tag, " idexCtrl"}, {22'b0, bus.idexCtrl}, 32'h0);
        check({tag, " idexValid"}, {31'b0, bus.idexValid}, 32'h0);
        check({tag, " pipeState"}, {30'b0, bus.pipeState}, 32'h0);
        check({tag, " stallCount"}, {16'b0, bus.stallCount}, 32'h0);
        check({tag, " flushCount"}, {16'b0, bus.flushCount}, 32'h0);
        check({tag, " stallTimeout"}, {31'b0, bus.stallTimeout}, 32'h0);
    endtask

    typedef struct {
        logic pcw, irw, zc, fl, src, jmp;
        logic [31:0] bt, jt, instr;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0] e_pc, e_instr, e_pc4;
        logic e_iv;
        logic [CTRL_W-1:0] e_ctrl;
        logic e_ev;
        logic [1:0] e_state;
        logic [15:0] e_stall, e_flush;
    } vec_t;

    vec_t vecs[11];

    // Behavioural reference: index 0 is the main instance, 1 the small one.
    logic [31:0]       m_pc, m_instr, m_pc4;
    logic              m_iv, m_ev;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_state;
    int                m_stall[2], m_flushc[2], m_run[2];
    bit                m_to[2];
    int                cnt_max[2] = '{65535, 7};
    int                lim[2]     = '{8, 1};

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_iv = 0; m_ev = 0; m_ctrl = 0; m_state = 0;
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = 0; m_flushc[k] = 0; m_run[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic model_step();
        logic [31:0] old_pc;
        logic        old_iv;
        bit          acc;
        old_pc = m_pc;
        old_iv = m_iv;
        if (bus.PcWrite) m_pc = bus.Jmp ? bus.jumpTarget : (bus.PcSrc ? bus.branchTarget : old_pc + 32'd4);
        if (bus.IRWrite) begin
            m_instr = bus.flush ? 32'h0 : bus.instrIn;
            m_pc4   = bus.flush ? 32'h0 : old_pc + 32'd4;
            m_iv    = !bus.flush;
        end
        m_ctrl = bus.zeroCntrl ? '0 : bus.ctrlIn;
        m_ev   = bus.zeroCntrl ? 1'b0 : old_iv;
        acc = bus.IRWrite && bus.flush && !bus.zeroCntrl;
        m_state = bus.zeroCntrl ? 2 : (acc ? 3 : 1);
        for (int k = 0; k < 2; k++) begin
            if (bus.zeroCntrl && m_stall[k] < cnt_max[k]) m_stall[k]++;
            if (acc && m_flushc[k] < cnt_max[k]) m_flushc[k]++;
            m_run[k] = bus.zeroCntrl ? ((m_run[k] < lim[k]) ? m_run[k] + 1 : lim[k]) : 0;
            if (m_run[k] >= lim[k]) m_to[k] = 1;
        end
    endtask

    task automatic model_compare();
        check("rnd pcOut", bus.pcOut, m_pc);
        check("rnd ifidInstr", bus.ifidInstr, m_instr);
        check("rnd ifidPc4", bus.ifidPc4, m_pc4);
        check("rnd ifidValid", {31'b0, bus.ifidValid}, {31'b0, m_iv});
        check("rnd idexCtrl", {22'b0, bus.idexCtrl}, {22'b0, m_ctrl});
        check("rnd idexValid", {31'b0, bus.idexValid}, {31'b0, m_ev});
        check("rnd pipeState", {30'b0, bus.pipeState}, m_state);
        check("rnd stallCount", {16'b0, bus.stallCount}, m_stall[0]);
        check("rnd flushCount", {16'b0, bus.flushCount}, m_flushc[0]);
        check("rnd stallTimeout", {31'b0, bus.stallTimeout}, {31'b0, m_to[0]});
        check("rnd small stallCount", {29'b0, bus_s.stallCount}, m_stall[1]);
        check("rnd small flushCount", {29'b0, bus_s.flushCount}, m_flushc[1]);
        check("rnd small stallTimeout", {31'b0, bus_s.stallTimeout}, {31'b0, m_to[1]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    localparam logic [31:0]       I0 = 32'h2001_0005;
    localparam logic [31:0]       I1 = 32'h8C22_0004;
    localparam logic [CTRL_W-1:0] C0 = 10'h155;
    localparam logic [CTRL_W-1:0] C1 = 10'h2AA;

    initial begin
        //           pcw irw zc fl src jmp bt     jt            instr ctrl  e_pc          e_instr e_pc4  iv e_ctrl ev st stall flush
        vecs[0]  = '{1, 1, 0, 0, 0, 0, 32'h0,  32'h0,        I0, C0, 32'h4,        I0,    32'h4,  1, C0,   0, 1, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 32'h0,  32'h0,        I0, C0, 32'h8,        I0,    32'h8,  1, C0,   1, 1, 0, 0};
        vecs[2]  = '{0, 0, 1, 0, 0, 0, 32'h0,  32'h0,        I0, C0, 32'h8,        I0,    32'h8,  1, 0,    0, 2, 1, 0};
        vecs[3]  = '{1, 1, 0, 0, 0, 0, 32'h0,  32'h0,        I0, C0, 32'hC,        I0,    32'hC,  1, C0,   1, 1, 1, 0};
        vecs[4]  = '{1, 1, 0, 1, 1, 0, 32'h40, 32'h0,        I0, C0, 32'h40,       0,     32'h0,  0, C0,   1, 3, 1, 1};
        vecs[5]  = '{1, 1, 0, 1, 1, 1, 32'h40, 32'h80,       I0, C0, 32'h80,       0,     32'h0,  0, C0,   0, 3, 1, 2};
        vecs[6]  = '{0, 0, 1, 1, 0, 0, 32'h0,  32'h0,        I0, C0, 32'h80,       0,     32'h0,  0, 0,    0, 2, 2, 2};
        vecs[7]  = '{1, 1, 0, 0, 0, 0, 32'h0,  32'h0,        I1, C1, 32'h84,       I1,    32'h84, 1, C1,   0, 1, 2, 2};
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 32'h0,  32'h0,        I0, C1, 32'h88,       I1,    32'h84, 1, C1,   1, 1, 2, 2};
        vecs[9]  = '{1, 1, 0, 0, 0, 1, 32'h0,  32'hFFFF_FFFC, I0, C0, 32'hFFFF_FFFC, I0,    32'h8C, 1, C0,   1, 1, 2, 2};
        vecs[10] = '{1, 1, 0, 0, 0, 0, 32'h0,  32'h0,        I0, C0, 32'h0,        I0,    32'h0,  1, C0,   1, 1, 2, 2};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].pcw, vecs[i].irw, vecs[i].zc, vecs[i].fl, vecs[i].src, vecs[i].jmp,
                  vecs[i].bt, vecs[i].jt, vecs[i].instr, vecs[i].ctrl);
            step();
            check($sformatf("vec%0d pcOut", i), bus.pcOut, vecs[i].e_pc);
            check($sformatf("vec%0d ifidInstr", i), bus.ifidInstr, vecs[i].e_instr);
            check($sformatf("vec%0d ifidPc4", i), bus.ifidPc4, vecs[i].e_pc4);
            check($sformatf("vec%0d ifidValid", i), {31'b0, bus.ifidValid}, {31'b0, vecs[i].e_iv});
            check($sformatf("vec%0d idexCtrl", i), {22'b0, bus.idexCtrl}, {22'b0, vecs[i].e_ctrl});
            check($sformatf("vec%0d idexValid", i), {31'b0, bus.idexValid}, {31'b0, vecs[i].e_ev});
            check($sformatf("vec%0d pipeState", i), {30'b0, bus.pipeState}, {30'b0, vecs[i].e_state});
            check($sformatf("vec%0d stallCount", i), {16'b0, bus.stallCount}, {16'b0, vecs[i].e_stall});
            check($sformatf("vec%0d flushCount", i), {16'b0, bus.flushCount}, {16'b0, vecs[i].e_flush});
        end

        // Watchdog: a 7-cycle run stays quiet, an 8-cycle run trips on its 8th edge.
        drive(0, 0, 1, 0, 0, 0, 0, 0, I0, C0);
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("wd run1 edge%0d stallTimeout", i + 1), {31'b0, bus.stallTimeout}, 32'h0);
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0, I0, C0);
        step();
        check("wd gap stallTimeout", {31'b0, bus.stallTimeout}, 32'h0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, I0, C0);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("wd run2 edge%0d stallTimeout", i + 1), {31'b0, bus.stallTimeout},
                  (i == 7) ? 32'h1 : 32'h0);
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0, I0, C0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("wd sticky stallTimeout", {31'b0, bus.stallTimeout}, 32'h1);
        end
        check("wd stallCount", {16'b0, bus.stallCount}, 32'd17);
        check("wd pipeState", {30'b0, bus.pipeState}, 32'd1);

        // Async reset asserted mid-stall, between clock edges.
        drive(0, 0, 1, 0, 0, 0, 0, 0, I0, C0);
        step();
        check("pre-reset pipeState", {30'b0, bus.pipeState}, 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("async reset");
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 0, 0, I0, C0);
        step();
        check("post-reset pipeState", {30'b0, bus.pipeState}, 32'd1);
        check("post-reset pcOut", bus.pcOut, 32'h4);

        // Random stimulus against the reference model.
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic zc, fl, irw;
            zc  = ((cyc % 97) < 10) ? 1'b1 : ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 3) == 0);
            irw = (zc && fl) ? 1'b0 : ($urandom_range(0, 4) != 0);
            drive($urandom_range(0, 4) != 0, irw, zc, fl,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  {$urandom_range(0, 32'h3FFF), 2'b00}, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF), 2'b00},
                  $urandom, CTRL_W'($urandom));
            step();
            model_step();
            model_compare();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_front_ctrl.md
Name: pipe_front_ctrl

Overview:
Front-end pipeline register controller for the 5-stage MIPS core. It consumes the stall/flush directives produced by the hazard detection logic (zeroCntrl, PcWrite, IRWrite, flush) together with PcSrc/Jmp. It owns the PC register, the IF/ID register and the control half of the ID/EX register, and applies holds, NOP flushes and bubble insertion. It also keeps stall/flush statistics and raises a stall watchdog flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CTRL_W, 10, width of the decoded control bundle passed ID->EX
CNT_W, 16, width of the stall/flush statistics counters
STALL_LIMIT, 8, consecutive stall cycles that trip the watchdog (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
PcWrite  in  1  1 = PC may update this cycle
IRWrite  in  1  1 = IF/ID may update this cycle
zeroCntrl  in  1  1 = inject bubble into ID/EX
flush  in  1  1 = replace IF/ID contents with NOP
PcSrc  in  1  taken branch resolved in ID
Jmp  in  1  jump decoded in ID
branchTarget  in  32  branch target address
jumpTarget  in  32  jump target address
instrIn  in  32  instruction read from instruction memory at pcOut
ctrlIn  in  CTRL_W  control bundle decoded from ifidInstr
pcOut  out  32  current PC (instruction memory address)
ifidInstr  out  32  IF/ID instruction
ifidPc4  out  32  IF/ID PC+4
ifidValid  out  1  IF/ID holds a real instruction
idexCtrl  out  CTRL_W  ID/EX control bundle
idexValid  out  1  ID/EX holds a real instruction
pipeState  out  2  00 BOOT, 01 RUN, 10 STALL, 11 FLUSH
stallCount  out  CNT_W  saturating count of bubble cycles
flushCount  out  CNT_W  saturating count of accepted flushes
stallTimeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, any time, including mid-stall): pcOut=RESET_PC. ifidInstr, ifidPc4 and idexCtrl are 0. ifidValid=idexValid=0, pipeState=BOOT, both counters 0, stallTimeout=0. All registers update on the rising clk edge only.
- PC update: if PcWrite=0, hold. Else if Jmp, load jumpTarget. Else if PcSrc, load branchTarget. Else load pcOut+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0). Jmp has priority over PcSrc.
- IF/ID update:
  - If IRWrite=0, hold all three fields.
  - Else if flush=1, load ifidInstr=0 (NOP), ifidPc4=0, ifidValid=0.
  - Else load ifidInstr=instrIn, ifidPc4=pcOut+4, ifidValid=1.
- ID/EX update: if zeroCntrl=1, load idexCtrl=0 and idexValid=0 (bubble). Else load idexCtrl=ctrlIn and idexValid=ifidValid. ctrlIn is taken as-is; no decoding here.
- Simultaneous stall and flush (zeroCntrl=1 with flush=1): the stall wins. IF/ID holds per IRWrite=0, the flush is not counted, and the flush is expected to be re-presented after the stall clears.
- PcWrite=1 with IRWrite=0 is legal and handled independently: the PC advances and IF/ID holds.
- Latency: one cycle for every register; no combinational path from inputs to outputs.
- pipeState FSM, registered, describes the action taken at the last edge:
  - BOOT: -> STALL if zeroCntrl, else FLUSH if accepted flush, else RUN.
  - RUN, STALL, FLUSH: same rule applied every cycle.
  - BOOT is left after exactly one edge and is re-entered only via reset.
- stallCount: +1 per edge with zeroCntrl=1; saturates at all-ones.
- flushCount: +1 per edge with an accepted flush (IRWrite=1 and flush=1); saturates at all-ones.
- Watchdog:
  - An internal run-length counter increments on each edge with zeroCntrl=1 and clears on any edge with zeroCntrl=0.
  - When the counter reaches STALL_LIMIT, stallTimeout is set at that edge and stays set until reset.
  - The run-length counter saturates at STALL_LIMIT.

Test Plan:
- Reset then 3 free-run cycles with instrIn=32'h2001_0005, PcWrite=IRWrite=1 -> pcOut 0,4,8,12; ifidPc4=4 after the first edge; ifidValid=1; pipeState BOOT then RUN.
- Load-use stall: zeroCntrl=1, PcWrite=IRWrite=0 for 1 cycle at pcOut=8 -> pcOut stays 8, ifid fields held, idexCtrl=0, idexValid=0, stallCount=1, pipeState=STALL.
- Taken branch: PcSrc=1, flush=1, branchTarget=32'h40 -> pcOut=0x40, ifidInstr=0, ifidValid=0, flushCount=1, pipeState=FLUSH; Jmp=1 and PcSrc=1 together with jumpTarget=0x80 -> pcOut=0x80.
- Conflict: zeroCntrl=1, flush=1, PcWrite=IRWrite=0 -> IF/ID held, flushCount unchanged, stallCount +1.
- Watchdog: zeroCntrl=1 for 7 cycles then 0, then 8 cycles -> stallTimeout stays 0 after the first run and is set at the 8th edge of the second run; it remains 1 afterwards.
- Wrap and async reset: PC forced to 32'hFFFF_FFFC by jumpTarget -> next pcOut=0; assert rst mid-stall between edges -> all outputs return to reset values immediately.
